// File: rtl/mic_pkg.sv
// Shared constants and helpers for the microphone PCM datapath.
package mic_pkg;

    localparam int unsigned PCM_WIDTH_DEF = 19;

    // Bit offset of a channel lane inside a packed frame.
    function automatic int unsigned lane_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

    // (ptr - d) modulo depth, with ptr and d both already below depth.
    function automatic int unsigned ring_sub(input int unsigned ptr, input int unsigned d,
                                             input int unsigned depth);
        return (ptr >= d) ? (ptr - d) : (ptr + depth - d);
    endfunction

    // Address width for a memory of the given depth, never below one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pcm_ring_buffer.sv
// Single-channel sample ring: one write port, combinational-address read with registered output.
module pcm_ring_buffer
    import mic_pkg::*;
#(
    parameter int unsigned WIDTH = PCM_WIDTH_DEF,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_zero,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reading the slot being written this cycle returns the new sample (zero-delay path).
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (rd_zero) begin
                rd_data <= '0;
            end else if (we && (rd_addr == wr_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/multichannel_delay_line.sv
// Per-channel programmable sample delay over a shared write pointer and fill counter.
module multichannel_delay_line
    import mic_pkg::*;
#(
    parameter int unsigned PCM_WIDTH = PCM_WIDTH_DEF,
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned MAX_DELAY = 63,
    localparam int unsigned DW       = addr_width(MAX_DELAY + 1),
    localparam int unsigned CW       = addr_width(CHANNELS),
    localparam int unsigned FW       = CHANNELS * PCM_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [FW-1:0] in_data,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [DW-1:0] cfg_delay,
    output logic          out_valid,
    output logic [FW-1:0] out_data,
    output logic          cfg_err
);

    localparam int unsigned DEPTH = MAX_DELAY + 1;

    logic [DW-1:0] wr_ptr;
    logic [DW-1:0] fill;
    logic [DW-1:0] delay_tab [CHANNELS];
    logic          wr_en_c;

    assign wr_en_c = in_valid & rst;

    // Shared write pointer and saturating count of frames since reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (in_valid) begin
            wr_ptr <= (wr_ptr == DW'(MAX_DELAY)) ? '0 : wr_ptr + DW'(1);
            fill   <= (fill == DW'(MAX_DELAY)) ? fill : fill + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Delay table; out-of-range channels are dropped, oversize delays clamped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                delay_tab[c] <= '0;
            end
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            if (32'(cfg_ch) >= CHANNELS) begin
                cfg_err <= 1'b1;
            end else if (32'(cfg_delay) > MAX_DELAY) begin
                delay_tab[cfg_ch] <= DW'(MAX_DELAY);
                cfg_err           <= 1'b1;
            end else begin
                delay_tab[cfg_ch] <= cfg_delay;
            end
        end
    end

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
        logic [DW-1:0] rd_idx_c;
        logic          rd_zero_c;

        // Channels whose delay reaches before the first frame since reset read as silence.
        assign rd_idx_c  = DW'(ring_sub(32'(wr_ptr), 32'(delay_tab[c]), DEPTH));
        assign rd_zero_c = (delay_tab[c] > fill);

        pcm_ring_buffer #(
            .WIDTH (PCM_WIDTH),
            .DEPTH (DEPTH),
            .AW    (DW)
        ) u_ring (
            .clk     (clk),
            .rst     (rst),
            .we      (wr_en_c),
            .wr_addr (wr_ptr),
            .wr_data (in_data[lane_lsb(c, PCM_WIDTH) +: PCM_WIDTH]),
            .rd_en   (in_valid),
            .rd_zero (rd_zero_c),
            .rd_addr (rd_idx_c),
            .rd_data (out_data[lane_lsb(c, PCM_WIDTH) +: PCM_WIDTH])
        );
    end

endmodule
